// File: rtl/seg7_scanner.sv
// Eight-digit multiplexed seven-segment scanner.
// A snapshot taken once per frame keeps the display from tearing.
module seg7_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] val,
  input  logic        en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [7:0]    nzn;
  logic [7:0]    blank;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = en && (cnt == LAST);
  assign wrap = tick && (idx == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en)
        cnt <= tick ? '0 : cnt + CW'(1);
      if (tick)
        idx <= idx + 3'd1;
      if (wrap)
        snap <= val;
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    nzn = '0;
    for (int i = 0; i < 8; i++)
      nzn[i] = |snap[4*i +: 4];
  end

  always_comb begin
    blank = '0;
    for (int i = 1; i < 8; i++)
      blank[i] = ~|(nzn >> i);
  end

  always_comb begin
    nib   = snap[{idx, 2'b00} +: 4];
    an_d  = ~(8'b1 << idx);
    dp_d  = ~dp_mask[idx];
    seg_d = (BLANK_LZ && blank[idx]) ? 7'h7F : hex7(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (!en) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
